// File: rtl/adder_tree_stream.sv
// Streaming registered binary adder tree with optional frame accumulation and a
// single output register; the whole pipe advances together under one stall signal.
//
//   state | meaning
//   FIRST | next tree sum starts a frame (or is a standalone result)
//   MID   | partial frame sum held in acc, waiting for the closing beat
module adder_tree_stream #(
    parameter int IN_NUM    = 16,
    parameter int DIN_WIDTH = 8,
    parameter int SIGNED    = 0,
    parameter int ACC_EXTRA = 8
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [IN_NUM*DIN_WIDTH-1:0]                      din,
    input  logic                                             din_valid,
    input  logic                                             din_last,
    input  logic                                             acc_en,
    output logic                                             din_ready,
    output logic [DIN_WIDTH+$clog2(IN_NUM)+ACC_EXTRA-1:0]    dout,
    output logic                                             dout_ovf,
    output logic                                             dout_valid,
    input  logic                                             dout_ready
);

    localparam int LAYER_NUM  = $clog2(IN_NUM);
    localparam int OUT_WIDTH  = DIN_WIDTH + LAYER_NUM + ACC_EXTRA;
    localparam int PAD_NUM    = 1 << LAYER_NUM;
    localparam int TREE_WIDTH = DIN_WIDTH + LAYER_NUM;

    typedef enum logic {FIRST, MID} frame_t;

    logic                  adv;
    logic [TREE_WIDTH-1:0] leaf [PAD_NUM];
    logic [DIN_WIDTH-1:0]  word;
    // Layers packed back to back: layer k starts at PAD_NUM - (PAD_NUM >> (k-1)).
    logic [TREE_WIDTH-1:0] node [PAD_NUM-1];
    logic [LAYER_NUM:1]    lay_valid;
    logic [LAYER_NUM:1]    lay_last;
    logic [LAYER_NUM:1]    lay_acc;
    logic [TREE_WIDTH-1:0] root;
    logic [OUT_WIDTH-1:0]  s_ext;
    logic [OUT_WIDTH-1:0]  acc;
    logic                  acc_ovf;
    logic [OUT_WIDTH:0]    acc_sum;
    logic                  wrap;
    frame_t                frame;

    assign adv       = !dout_valid || dout_ready;
    assign din_ready = adv;

    // Leaves are extended to the full tree width so every layer adds exactly.
    always_comb begin
        leaf = '{default: '0};
        word = '0;
        for (int i = 0; i < IN_NUM; i++) begin
            word = din[i*DIN_WIDTH +: DIN_WIDTH];
            if (SIGNED != 0) leaf[i] = TREE_WIDTH'($signed(word));
            else             leaf[i] = TREE_WIDTH'(word);
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            for (int i = 0; i < PAD_NUM / 2; i++)
                node[i] <= leaf[2*i] + leaf[2*i+1];
            for (int k = 2; k <= LAYER_NUM; k++)
                for (int i = 0; i < (PAD_NUM >> k); i++)
                    node[PAD_NUM - (PAD_NUM >> (k-1)) + i] <=
                        node[PAD_NUM - (PAD_NUM >> (k-2)) + 2*i] +
                        node[PAD_NUM - (PAD_NUM >> (k-2)) + 2*i + 1];
        end
    end

    assign root    = node[PAD_NUM-2];
    assign s_ext   = (SIGNED != 0) ? OUT_WIDTH'($signed(root)) : OUT_WIDTH'(root);
    assign acc_sum = {1'b0, acc} + {1'b0, s_ext};
    assign wrap    = (SIGNED != 0)
                   ? ((acc[OUT_WIDTH-1] == s_ext[OUT_WIDTH-1]) &&
                      (acc_sum[OUT_WIDTH-1] != acc[OUT_WIDTH-1]))
                   : acc_sum[OUT_WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lay_valid  <= '0;
            lay_last   <= '0;
            lay_acc    <= '0;
            frame      <= FIRST;
            acc        <= '0;
            acc_ovf    <= 1'b0;
            dout       <= '0;
            dout_ovf   <= 1'b0;
            dout_valid <= 1'b0;
        end else if (adv) begin
            lay_valid[1] <= din_valid;
            lay_last[1]  <= din_last;
            lay_acc[1]   <= acc_en;
            for (int k = 2; k <= LAYER_NUM; k++) begin
                lay_valid[k] <= lay_valid[k-1];
                lay_last[k]  <= lay_last[k-1];
                lay_acc[k]   <= lay_acc[k-1];
            end
            dout_valid <= 1'b0;
            if (lay_valid[LAYER_NUM]) begin
                case (frame)
                    FIRST: begin
                        if (!lay_acc[LAYER_NUM] || lay_last[LAYER_NUM]) begin
                            dout       <= s_ext;
                            dout_ovf   <= 1'b0;
                            dout_valid <= 1'b1;
                        end else begin
                            acc     <= s_ext;
                            acc_ovf <= 1'b0;
                            frame   <= MID;
                        end
                    end
                    MID: begin
                        // acc_en dropping mid-frame closes the frame like last.
                        if (!lay_acc[LAYER_NUM] || lay_last[LAYER_NUM]) begin
                            dout       <= acc_sum[OUT_WIDTH-1:0];
                            dout_ovf   <= acc_ovf | wrap;
                            dout_valid <= 1'b1;
                            frame      <= FIRST;
                        end else begin
                            acc     <= acc_sum[OUT_WIDTH-1:0];
                            acc_ovf <= acc_ovf | wrap;
                        end
                    end
                    default: frame <= FIRST;
                endcase
            end
        end
    end

endmodule

// File: doc/adder_tree_stream.md
Name: adder_tree_stream

Overview:
- Streaming, fully pipelined reduction adder for an arbitrary input count: IN_NUM words are summed in a registered binary tree, one register layer per tree layer.
- Unsigned or signed operation is set by parameter.
- Optional multi-beat accumulation adds the tree sums over a frame delimited by din_last.
- Valid/ready handshakes on input and output, with full-pipeline stall on backpressure. Intended as the general reduction engine for the dot-product and filter datapaths.

Parameters:
- IN_NUM, 16, number of input words; any value >= 2. Non-power-of-two counts are zero-padded to the next power of two.
- DIN_WIDTH, 8, width of each input word.
- SIGNED, 0, 0 = unsigned two's-complement-free arithmetic; 1 = signed, sign-extended at every layer.
- ACC_EXTRA, 8, extra accumulator bits beyond the tree growth.
- Derived, not overridable: LAYER_NUM = clog2(IN_NUM); OUT_WIDTH = DIN_WIDTH + LAYER_NUM + ACC_EXTRA.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- din  input  IN_NUM*DIN_WIDTH  packed words; word i is din[i*DIN_WIDTH +: DIN_WIDTH].
- din_valid  input  1  input beat valid.
- din_last  input  1  last beat of an accumulation frame; meaningful only with acc_en.
- acc_en  input  1  1 = accumulate over the frame; 0 = every beat produces a result. Sampled with the beat.
- din_ready  output  1  input can be accepted this cycle.
- dout  output  OUT_WIDTH  result.
- dout_ovf  output  1  result wrapped, under the SIGNED interpretation.
- dout_valid  output  1  result valid.
- dout_ready  input  1  downstream accepts the result.

Behaviour:
- Reset: rst_n low at a rising clk edge clears the following.
  - All layer valid, last and acc_en bits.
  - The accumulator and the frame state, which returns to FIRST.
  - Outputs: dout=0, dout_ovf=0, dout_valid=0.
  - Data registers need not be cleared.
  - din_ready is combinational and follows the stall rule below.
  - Reset mid-frame discards the partial frame; no result is emitted for it.
- Handshake:
  - A beat is accepted when din_valid && din_ready.
  - A result is consumed when dout_valid && dout_ready.
  - Global advance: adv = !dout_valid || dout_ready. din_ready = adv.
  - When adv=0, every pipeline register, the accumulator and dout hold their values.
  - Bubbles (valid=0) propagate normally and do not occupy the output.
- Tree:
  - Layer k (k=1..LAYER_NUM) registers ceil(IN_NUM/2^k) sums of width DIN_WIDTH+k.
  - Operands are sign-extended when SIGNED=1 and zero-extended otherwise.
  - An unpaired odd element is added to zero, i.e. passed through extended.
  - Each layer carries its valid, last and acc_en bits alongside the data.
  - Tree arithmetic is exact; there is no overflow inside the tree.
- Accumulator stage, one register stage fed by layer LAYER_NUM (sum s, extended to OUT_WIDTH):
  - Frame state FIRST: if acc_en=0 or last=1, load the output with s and assert dout_valid; state stays FIRST. Otherwise set acc=s and go to MID.
  - Frame state MID: acc_next = acc + s. If last=1, load dout=acc_next, assert dout_valid and go to FIRST. Otherwise set acc=acc_next and stay in MID.
  - acc_en=0 while in MID: treated as last; the frame closes with acc+s.
  - Accumulation wraps modulo 2^OUT_WIDTH.
  - dout_ovf = OR of all wrap events in the frame. Unsigned: carry out. Signed: operands of equal sign giving a result of opposite sign.
  - Single-beat results never set dout_ovf.
- Latency:
  - An accepted beat that completes a result shows dout_valid exactly LAYER_NUM+1 cycles after acceptance, when unstalled.
  - Throughput is one beat per cycle.
  - The output is a single register. While dout_valid=1 and dout_ready=0 the whole pipe stalls; no data is lost or duplicated.
  - Consume and new result in the same cycle: dout reloads with no bubble.
- Simultaneous events:
  - din_last is ignored when acc_en=0.
  - A beat with din_valid=0 does not change the frame state, even if din_last or acc_en toggles.

Test Plan:
- IN_NUM=4, DIN_WIDTH=8, SIGNED=0, acc_en=0, all words 255 -> dout=1020, dout_ovf=0, dout_valid 3 cycles after acceptance.
- IN_NUM=5, SIGNED=0, words 1,2,3,4,5, 8 back-to-back beats -> each dout=15, latency 4, dout_valid high 8 consecutive cycles.
- IN_NUM=16, SIGNED=1, all words -128 -> dout=-2048 (sign-extended across OUT_WIDTH); mixed words 127 and -128 alternating -> dout=-8.
- acc_en=1, IN_NUM=4, three beats of all 10 with last on beat 3 -> one result dout=120; no dout_valid for beats 1-2.
- ACC_EXTRA=0, IN_NUM=2, DIN_WIDTH=4, unsigned, frame of two beats of all 15 -> dout=60 mod 32=28, dout_ovf=1.
- Hold dout_ready=0 for 5 cycles during a stream of 10 beats: din_ready drops, dout holds, and all 10 results arrive in order. Then reset mid-frame: dout_valid=0, dout=0, and the next frame's sum excludes pre-reset beats.
